elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
Clocked SCAN-policy controller for a single elevator car. It latches car-panel and hall up/down calls, chooses the travel direction and drives the motor code. It decides at which floors to stop, and sequences the door dwell. It sits between the call-button inputs and the motor and door drivers, and replaces ad-hoc combinational sequencing with a synchronous FSM.

Parameters:
NUM_FLOORS, 4, number of served floors (2..16)
FLOOR_W, 2, width of floor index, equals clog2(NUM_FLOORS)
DOOR_CYCLES, 8, clock cycles the door stays open (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  reset, synchronous, active-low
car_req  input  NUM_FLOORS  car-panel call per floor, 1-cycle pulse or level
hall_up  input  NUM_FLOORS  hall up-call per floor
hall_dn  input  NUM_FLOORS  hall down-call per floor
floor  input  FLOOR_W  current floor from position sensor
at_floor  input  1  car aligned with `floor`
motor  output  2  00 stop, 01 up, 10 down (11 never driven)
door_open  output  1  door command
dir  output  2  committed direction: 00 none, 01 up, 10 down
state  output  2  FSM state, debug
car_pend, up_pend, dn_pend  output  NUM_FLOORS each  latched pending calls

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE, motor=00, door_open=0, dir=00.
  - All pend vectors 0, door counter 0.
  - Applies mid-travel or mid-dwell; no request survives.
- Latching: each cycle pend |= request vector.
- Serving a floor f clears car_pend[f] plus the served hall bit(s):
  - up_pend[f] if dir=UP; dn_pend[f] if dir=DOWN; all three bits if dir=NONE.
  - On the same cycle, clear beats set for a served bit; set wins for unserved bits.
- Definitions: above(f) = any pend bit at index >f; below(f) = any pend bit at index <f.
- motor and door_open are registered decodes of the next state, so they change on the same edge as state.
- FSM states: IDLE=00, MOVE_UP=01, MOVE_DN=10, DOOR=11.
- IDLE:
  - Priority 1: at_floor and any pend at floor (including a same-cycle request) -> DOOR; serve f with dir=NONE.
  - Else if dir=UP and above -> MOVE_UP.
  - Else if dir=DOWN and below -> MOVE_DN.
  - Else if above -> MOVE_UP, dir=UP.
  - Else if below -> MOVE_DN, dir=DOWN.
  - Else stay, dir=NONE.
- MOVE_UP: at_floor is required, then:
  - Stop when car_pend[f] | up_pend[f] | (dn_pend[f] & !above(f)) -> DOOR.
    - If the stop was caused by dn_pend only, dir becomes DOWN before serving.
  - Forced stop: floor==NUM_FLOORS-1 with no stop condition -> IDLE.
- MOVE_DN: mirror image of MOVE_UP.
  - Stop on car_pend|dn_pend, or up_pend & !below.
  - Forced stop at floor 0.
- DOOR:
  - On entry, counter loads DOOR_CYCLES-1 and decrements each cycle.
  - When counter==0 -> IDLE. door_open=1 for exactly DOOR_CYCLES cycles.
  - A request at the current floor while in DOOR is ignored and not latched if it matches the served type.
  - Other requests latch normally.
- Requests for the current floor during MOVE_* with at_floor are handled as the stop condition evaluated on that cycle.
- Latency: request pulse -> visible in pend next cycle; IDLE -> MOVE decision one cycle after latch.

Optional Feature:
ELEV_DOOR_HOLD_EN:
- When defined, adds input door_hold (1 bit).
  - While door_hold=1 in DOOR, the counter reloads DOOR_CYCLES-1, so the door stays open.
  - The door closes DOOR_CYCLES cycles after door_hold deasserts.
- Without the macro, the port is absent and the dwell is fixed.

Decomposition:
- Package elev_pkg holds:
  - state_t enum (IDLE, MOVE_UP, MOVE_DN, DOOR)
  - motor codes MOTOR_STOP/UP/DN
  - dir codes DIR_NONE/UP/DN
- One sub-module, elev_door_timer: load/hold/decrement counter with a done flag, parameterised by DOOR_CYCLES.
- above/below reductions are local functions.

Test Plan:
1. Reset with car_req=4'b1000 asserted -> all pend 0, motor=00; after reset release, car_pend=4'b1000 next cycle.
2. Car at floor 0 idle, car_req[2] pulse -> MOVE_UP (motor=01). At floor 1 with at_floor: no stop. At floor 2: DOOR, door_open high 8 cycles, car_pend[2] cleared, then IDLE, dir=NONE.
3. Moving up from floor 0 with car_pend[3] and hall_dn[1] set -> passes floor 1, stops at 3, then reverses (MOVE_DN) and stops at 1 with dn_pend[1] cleared.
4. Moving up with only hall_dn[2] pending -> stops at 2, dir becomes DOWN, dn_pend[2] cleared.
5. Idle at floor 1 with at_floor, hall_up[1] pulse -> DOOR next edge, no motor movement, up_pend stays 0.
6. Reset asserted mid-DOOR at cycle 3 -> door_open=0, state=IDLE next edge; with ELEV_DOOR_HOLD_EN, door_hold held 20 cycles -> door_open high 20+8 cycles.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared types and output codes for the elevator scheduler.
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MOVE_UP = 2'b01,
    MOVE_DN = 2'b10,
    DOOR    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DN   = 2'b10;

endpackage

// File: rtl/elev_door_timer.sv
// Door dwell counter: load/hold to DOOR_CYCLES-1, decrement while enabled, done at zero.
module elev_door_timer #(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_hold,
  input  logic i_en,
  output logic o_done
);

  localparam int unsigned        CNT_W = $clog2(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DOOR_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load || i_hold) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A held door never reports done, even if the count happens to be zero.
  assign o_done = (r_cnt == '0) && !i_hold;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy single-car elevator controller: call latching, direction, stops, door dwell.
// Optional door_hold input enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 4,
  parameter int unsigned FLOOR_W     = 2,
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  at_floor,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [1:0]            motor,
  output logic                  door_open,
  output logic [1:0]            dir,
  output logic [1:0]            state,
  output logic [NUM_FLOORS-1:0] car_pend,
  output logic [NUM_FLOORS-1:0] up_pend,
  output logic [NUM_FLOORS-1:0] dn_pend
);

  state_t r_state, w_state_nxt;
  dir_t   r_dir, w_dir_nxt, w_serve_dir;
  logic   w_serve;
  logic [1:0] r_motor, w_motor_nxt;
  logic   r_door_open;
  logic [NUM_FLOORS-1:0] r_car_pend, r_up_pend, r_dn_pend;
  logic [NUM_FLOORS-1:0] w_car_m, w_up_m, w_dn_m, w_any_lat, w_any_m, w_floor_oh;
  logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic w_car_here, w_up_here, w_dn_here;
  logic w_above_lat, w_below_lat, w_above_m, w_below_m;
  logic w_timer_load, w_timer_hold, w_timer_done;

  function automatic logic f_above(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if ((i > 32'(f)) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic f_below(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if ((i < 32'(f)) && v[i]) r = 1'b1;
    return r;
  endfunction

  // Merged vectors include this cycle's requests; idle travel decisions use latched calls only.
  assign w_car_m     = r_car_pend | car_req;
  assign w_up_m      = r_up_pend | hall_up;
  assign w_dn_m      = r_dn_pend | hall_dn;
  assign w_any_lat   = r_car_pend | r_up_pend | r_dn_pend;
  assign w_any_m     = w_car_m | w_up_m | w_dn_m;
  assign w_floor_oh  = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor;
  assign w_car_here  = |(w_car_m & w_floor_oh);
  assign w_up_here   = |(w_up_m & w_floor_oh);
  assign w_dn_here   = |(w_dn_m & w_floor_oh);
  assign w_above_lat = f_above(w_any_lat, floor);
  assign w_below_lat = f_below(w_any_lat, floor);
  assign w_above_m   = f_above(w_any_m, floor);
  assign w_below_m   = f_below(w_any_m, floor);

`ifdef ELEV_DOOR_HOLD_EN
  assign w_timer_hold = (r_state == DOOR) && door_hold;
`else
  assign w_timer_hold = 1'b0;
`endif
  assign w_timer_load = (w_state_nxt == DOOR) && (r_state != DOOR);

  elev_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_timer_load),
    .i_hold (w_timer_hold),
    .i_en   (r_state == DOOR),
    .o_done (w_timer_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_serve     = 1'b0;
    w_serve_dir = r_dir;
    unique case (r_state)
      IDLE: begin
        if (at_floor && (w_car_here || w_up_here || w_dn_here)) begin
          w_state_nxt = DOOR;
          w_dir_nxt   = DIR_NONE;
          w_serve     = 1'b1;
          w_serve_dir = DIR_NONE;
        end else if (r_dir == DIR_UP && w_above_lat) begin
          w_state_nxt = MOVE_UP;
        end else if (r_dir == DIR_DN && w_below_lat) begin
          w_state_nxt = MOVE_DN;
        end else if (w_above_lat) begin
          w_state_nxt = MOVE_UP;
          w_dir_nxt   = DIR_UP;
        end else if (w_below_lat) begin
          w_state_nxt = MOVE_DN;
          w_dir_nxt   = DIR_DN;
        end else begin
          w_dir_nxt   = DIR_NONE;
        end
      end
      MOVE_UP: begin
        if (at_floor) begin
          if (w_car_here || w_up_here) begin
            w_state_nxt = DOOR;
            w_serve     = 1'b1;
            w_serve_dir = DIR_UP;
          end else if (w_dn_here && !w_above_m) begin
            w_state_nxt = DOOR;
            w_dir_nxt   = DIR_DN;
            w_serve     = 1'b1;
            w_serve_dir = DIR_DN;
          end else if (floor == FLOOR_W'(NUM_FLOORS - 1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      MOVE_DN: begin
        if (at_floor) begin
          if (w_car_here || w_dn_here) begin
            w_state_nxt = DOOR;
            w_serve     = 1'b1;
            w_serve_dir = DIR_DN;
          end else if (w_up_here && !w_below_m) begin
            w_state_nxt = DOOR;
            w_dir_nxt   = DIR_UP;
            w_serve     = 1'b1;
            w_serve_dir = DIR_UP;
          end else if (floor == '0) begin
            w_state_nxt = IDLE;
          end
        end
      end
      DOOR: begin
        // Keep serving the open floor so matching calls never latch during dwell.
        w_serve     = 1'b1;
        w_serve_dir = r_dir;
        if (w_timer_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_motor_nxt = MOTOR_STOP;
    if (w_state_nxt == MOVE_UP) w_motor_nxt = MOTOR_UP;
    else if (w_state_nxt == MOVE_DN) w_motor_nxt = MOTOR_DN;
  end

  assign w_clr_car = w_serve ? w_floor_oh : '0;
  assign w_clr_up  = (w_serve && w_serve_dir != DIR_DN) ? w_floor_oh : '0;
  assign w_clr_dn  = (w_serve && w_serve_dir != DIR_UP) ? w_floor_oh : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_dir       <= DIR_NONE;
      r_motor     <= MOTOR_STOP;
      r_door_open <= 1'b0;
      r_car_pend  <= '0;
      r_up_pend   <= '0;
      r_dn_pend   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_motor     <= w_motor_nxt;
      r_door_open <= (w_state_nxt == DOOR);
      r_car_pend  <= w_car_m & ~w_clr_car;
      r_up_pend   <= w_up_m & ~w_clr_up;
      r_dn_pend   <= w_dn_m & ~w_clr_dn;
    end
  end

  assign motor     = r_motor;
  assign door_open = r_door_open;
  assign dir       = r_dir;
  assign state     = r_state;
  assign car_pend  = r_car_pend;
  assign up_pend   = r_up_pend;
  assign dn_pend   = r_dn_pend;

endmodule
